axi4_master_arbiter: RTL and testbench

N-to-1 AXI4 master arbiter that lets several DUT master ports share the single AXI4 master BFM port in the top-level simulation wrapper. It generalises the single-master top to C_MASTERS channels. AW and AR requests are arbitrated round-robin, and the master index is prefixed onto the transaction ID. W data follows AW grant order through an order FIFO. B and R responses are routed back by ID prefix.

---
 rtl/axi4_master_arbiter_pkg.sv | 17 +
 rtl/axi4_master_arbiter_rr.sv | 44 ++++
 rtl/axi4_master_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_axi4_master_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_master_arbiter_pkg.sv
// Shared definitions for the N-to-1 AXI4 master arbiter: ID-prefix width
// helpers and the write-order FIFO occupancy type.
package axi4_master_arbiter_pkg;

    localparam int FIFO_CNT_W = 8;

    typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;

    function automatic int calc_sw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int calc_miw(input int iw, input int n);
        return iw + calc_sw(n);
    endfunction

endpackage

// File: rtl/axi4_master_arbiter_rr.sv
// Round-robin request arbiter: one-hot grant searched from a rotating
// pointer, which advances past the winner only when the grant is accepted.
module axi4_rr_arbiter
    import axi4_master_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int SW = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req_i,
    input  logic          accept_i,
    output logic [N-1:0]  grant_o,
    output logic [SW-1:0] idx_o,
    output logic          any_o
);

    logic [SW-1:0] ptr_q;
    logic [SW-1:0] ptr_d;

    // Descending scan so the candidate closest to the pointer wins.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_q) + k) % N]) begin
                idx_o = SW'((int'(ptr_q) + k) % N);
                any_o = 1'b1;
            end
        end
    end

    assign grant_o = any_o ? (N'(1) << idx_o) : '0;
    assign ptr_d   = (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (accept_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axi4_master_arbiter.sv
// N-to-1 AXI4 master arbiter: round-robin AW/AR with master index prefixed on
// the ID, W steered by an AW-order FIFO, B/R routed back by ID prefix.
module axi4_master_arbiter
    import axi4_master_arbiter_pkg::*;
#(
    parameter int C_MASTERS           = 2,
    parameter int C_THREAD_ID_WIDTH   = 1,
    parameter int C_ADDR_WIDTH        = 32,
    parameter int C_DATA_WIDTH        = 128,
    parameter int C_MAX_OUTSTANDING_W = 4,
    localparam int SW  = calc_sw(C_MASTERS),
    localparam int MIW = calc_miw(C_THREAD_ID_WIDTH, C_MASTERS)
) (
    input  logic                                    MCLK,
    input  logic                                    nRST,
    input  logic [C_MASTERS*C_THREAD_ID_WIDTH-1:0]  S_AWID,
    input  logic [C_MASTERS*C_ADDR_WIDTH-1:0]       S_AWADDR,
    input  logic [C_MASTERS*8-1:0]                  S_AWLEN,
    input  logic [C_MASTERS*3-1:0]                  S_AWSIZE,
    input  logic [C_MASTERS*2-1:0]                  S_AWBURST,
    input  logic [C_MASTERS-1:0]                    S_AWVALID,
    output logic [C_MASTERS-1:0]                    S_AWREADY,
    input  logic [C_MASTERS*C_DATA_WIDTH-1:0]       S_WDATA,
    input  logic [C_MASTERS*C_DATA_WIDTH/8-1:0]     S_WSTRB,
    input  logic [C_MASTERS-1:0]                    S_WLAST,
    input  logic [C_MASTERS-1:0]                    S_WVALID,
    output logic [C_MASTERS-1:0]                    S_WREADY,
    output logic [C_MASTERS*C_THREAD_ID_WIDTH-1:0]  S_BID,
    output logic [C_MASTERS*2-1:0]                  S_BRESP,
    output logic [C_MASTERS-1:0]                    S_BVALID,
    input  logic [C_MASTERS-1:0]                    S_BREADY,
    input  logic [C_MASTERS*C_THREAD_ID_WIDTH-1:0]  S_ARID,
    input  logic [C_MASTERS*C_ADDR_WIDTH-1:0]       S_ARADDR,
    input  logic [C_MASTERS*8-1:0]                  S_ARLEN,
    input  logic [C_MASTERS*3-1:0]                  S_ARSIZE,
    input  logic [C_MASTERS*2-1:0]                  S_ARBURST,
    input  logic [C_MASTERS-1:0]                    S_ARVALID,
    output logic [C_MASTERS-1:0]                    S_ARREADY,
    output logic [C_MASTERS*C_THREAD_ID_WIDTH-1:0]  S_RID,
    output logic [C_MASTERS*C_DATA_WIDTH-1:0]       S_RDATA,
    output logic [C_MASTERS*2-1:0]                  S_RRESP,
    output logic [C_MASTERS-1:0]                    S_RLAST,
    output logic [C_MASTERS-1:0]                    S_RVALID,
    input  logic [C_MASTERS-1:0]                    S_RREADY,
    output logic [MIW-1:0]                          M_AWID,
    output logic [C_ADDR_WIDTH-1:0]                 M_AWADDR,
    output logic [7:0]                              M_AWLEN,
    output logic [2:0]                              M_AWSIZE,
    output logic [1:0]                              M_AWBURST,
    output logic                                    M_AWVALID,
    input  logic                                    M_AWREADY,
    output logic [C_DATA_WIDTH-1:0]                 M_WDATA,
    output logic [C_DATA_WIDTH/8-1:0]               M_WSTRB,
    output logic                                    M_WLAST,
    output logic                                    M_WVALID,
    input  logic                                    M_WREADY,
    input  logic [MIW-1:0]                          M_BID,
    input  logic [1:0]                              M_BRESP,
    input  logic                                    M_BVALID,
    output logic                                    M_BREADY,
    output logic [MIW-1:0]                          M_ARID,
    output logic [C_ADDR_WIDTH-1:0]                 M_ARADDR,
    output logic [7:0]                              M_ARLEN,
    output logic [2:0]                              M_ARSIZE,
    output logic [1:0]                              M_ARBURST,
    output logic                                    M_ARVALID,
    input  logic                                    M_ARREADY,
    input  logic [MIW-1:0]                          M_RID,
    input  logic [C_DATA_WIDTH-1:0]                 M_RDATA,
    input  logic [1:0]                              M_RRESP,
    input  logic                                    M_RLAST,
    input  logic                                    M_RVALID,
    output logic                                    M_RREADY
);

    localparam int N     = C_MASTERS;
    localparam int IW    = C_THREAD_ID_WIDTH;
    localparam int AW    = C_ADDR_WIDTH;
    localparam int DW    = C_DATA_WIDTH;
    localparam int DEPTH = C_MAX_OUTSTANDING_W;
    localparam int PW    = $clog2(DEPTH);

    logic [N-1:0]  aw_grant, ar_grant;
    logic [SW-1:0] aw_idx, ar_idx;
    logic          aw_any, ar_any;
    logic          aw_take, ar_take;

    logic [MIW-1:0] m_awid_q, m_arid_q;
    logic [AW-1:0]  m_awaddr_q, m_araddr_q;
    logic [7:0]     m_awlen_q, m_arlen_q;
    logic [2:0]     m_awsize_q, m_arsize_q;
    logic [1:0]     m_awburst_q, m_arburst_q;
    logic           m_awvalid_q, m_arvalid_q;

    logic [SW-1:0] wfifo_mem_q [DEPTH];
    logic [PW-1:0] wfifo_wr_q, wfifo_rd_q;
    fifo_cnt_t     wfifo_cnt_q;
    logic          wfifo_full, wfifo_empty, w_pop;
    logic [SW-1:0] w_head;

    axi4_rr_arbiter #(.N(N), .SW(SW)) u_aw_arb (
        .clk_i    (MCLK),
        .rst_ni   (nRST),
        .req_i    (S_AWVALID),
        .accept_i (aw_take),
        .grant_o  (aw_grant),
        .idx_o    (aw_idx),
        .any_o    (aw_any)
    );

    axi4_rr_arbiter #(.N(N), .SW(SW)) u_ar_arb (
        .clk_i    (MCLK),
        .rst_ni   (nRST),
        .req_i    (S_ARVALID),
        .accept_i (ar_take),
        .grant_o  (ar_grant),
        .idx_o    (ar_idx),
        .any_o    (ar_any)
    );

    // A full order FIFO blocks AW capture even when a pop lands this cycle.
    assign aw_take   = nRST && aw_any && (!m_awvalid_q || M_AWREADY) && !wfifo_full;
    assign ar_take   = nRST && ar_any && (!m_arvalid_q || M_ARREADY);
    assign S_AWREADY = aw_take ? aw_grant : '0;
    assign S_ARREADY = ar_take ? ar_grant : '0;

    always_ff @(posedge MCLK) begin
        if (!nRST) begin
            m_awvalid_q <= 1'b0;
            m_arvalid_q <= 1'b0;
        end else begin
            if (aw_take) m_awvalid_q <= 1'b1;
            else if (M_AWREADY) m_awvalid_q <= 1'b0;
            if (ar_take) m_arvalid_q <= 1'b1;
            else if (M_ARREADY) m_arvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge MCLK) begin
        if (aw_take) begin
            m_awid_q    <= {aw_idx, S_AWID[aw_idx*IW +: IW]};
            m_awaddr_q  <= S_AWADDR[aw_idx*AW +: AW];
            m_awlen_q   <= S_AWLEN[aw_idx*8 +: 8];
            m_awsize_q  <= S_AWSIZE[aw_idx*3 +: 3];
            m_awburst_q <= S_AWBURST[aw_idx*2 +: 2];
        end
        if (ar_take) begin
            m_arid_q    <= {ar_idx, S_ARID[ar_idx*IW +: IW]};
            m_araddr_q  <= S_ARADDR[ar_idx*AW +: AW];
            m_arlen_q   <= S_ARLEN[ar_idx*8 +: 8];
            m_arsize_q  <= S_ARSIZE[ar_idx*3 +: 3];
            m_arburst_q <= S_ARBURST[ar_idx*2 +: 2];
        end
    end

    assign M_AWID    = m_awid_q;
    assign M_AWADDR  = m_awaddr_q;
    assign M_AWLEN   = m_awlen_q;
    assign M_AWSIZE  = m_awsize_q;
    assign M_AWBURST = m_awburst_q;
    assign M_AWVALID = m_awvalid_q;
    assign M_ARID    = m_arid_q;
    assign M_ARADDR  = m_araddr_q;
    assign M_ARLEN   = m_arlen_q;
    assign M_ARSIZE  = m_arsize_q;
    assign M_ARBURST = m_arburst_q;
    assign M_ARVALID = m_arvalid_q;

    assign wfifo_full  = (wfifo_cnt_q == fifo_cnt_t'(DEPTH));
    assign wfifo_empty = (wfifo_cnt_q == '0);
    assign w_head      = wfifo_mem_q[wfifo_rd_q];
    assign w_pop       = !wfifo_empty && S_WVALID[w_head] && M_WREADY && S_WLAST[w_head];

    always_ff @(posedge MCLK) begin
        if (!nRST) begin
            wfifo_wr_q  <= '0;
            wfifo_rd_q  <= '0;
            wfifo_cnt_q <= '0;
        end else begin
            if (aw_take) wfifo_wr_q <= wfifo_wr_q + 1'b1;
            if (w_pop)   wfifo_rd_q <= wfifo_rd_q + 1'b1;
            wfifo_cnt_q <= wfifo_cnt_q + fifo_cnt_t'(aw_take) - fifo_cnt_t'(w_pop);
        end
    end

    always_ff @(posedge MCLK) begin
        if (aw_take) wfifo_mem_q[wfifo_wr_q] <= aw_idx;
    end

    // W steering depends only on the registered FIFO head, never on M_AWREADY.
    always_comb begin
        M_WDATA  = S_WDATA[w_head*DW +: DW];
        M_WSTRB  = S_WSTRB[w_head*(DW/8) +: DW/8];
        M_WLAST  = S_WLAST[w_head];
        M_WVALID = !wfifo_empty && S_WVALID[w_head];
        S_WREADY = '0;
        if (!wfifo_empty) S_WREADY[w_head] = M_WREADY;
    end

    logic [SW-1:0] b_sel, r_sel;
    logic          b_hit, r_hit;

    assign b_sel = M_BID[MIW-1:IW];
    assign r_sel = M_RID[MIW-1:IW];
    assign b_hit = (int'(b_sel) < N);
    assign r_hit = (int'(r_sel) < N);

    // Beats carrying an unknown prefix are sunk so the downstream never stalls.
    always_comb begin
        S_BVALID = '0;
        M_BREADY = 1'b1;
        S_RVALID = '0;
        M_RREADY = 1'b1;
        if (b_hit) begin
            S_BVALID[b_sel] = M_BVALID;
            M_BREADY        = S_BREADY[b_sel];
        end
        if (r_hit) begin
            S_RVALID[r_sel] = M_RVALID;
            M_RREADY        = S_RREADY[r_sel];
        end
    end

    assign S_BID   = {N{M_BID[IW-1:0]}};
    assign S_BRESP = {N{M_BRESP}};
    assign S_RID   = {N{M_RID[IW-1:0]}};
    assign S_RDATA = {N{M_RDATA}};
    assign S_RRESP = {N{M_RRESP}};
    assign S_RLAST = {N{M_RLAST}};

endmodule

// File: tb/tb_axi4_master_arbiter.sv
// Scenario bench for axi4_master_arbiter: a 2-master instance for the main
// paths and a 3-master instance for out-of-range response prefixes.
module tb_axi4_master_arbiter;

    localparam int N = 2, IW = 1, AW = 32, DW = 32, MIW = 2;
    localparam int N3 = 3, MIW3 = 3;

    logic MCLK = 1'b0;
    logic nRST;
    always #5 MCLK = ~MCLK;

    int total = 0;
    int bad = 0;
    int addr_seq = 0;

    logic [N*IW-1:0]   s_awid, s_arid, s_bid, s_rid;
    logic [N*AW-1:0]   s_awaddr, s_araddr;
    logic [N*8-1:0]    s_awlen, s_arlen;
    logic [N*3-1:0]    s_awsize, s_arsize;
    logic [N*2-1:0]    s_awburst, s_arburst, s_bresp, s_rresp;
    logic [N-1:0]      s_awvalid, s_awready, s_arvalid, s_arready;
    logic [N*DW-1:0]   s_wdata, s_rdata;
    logic [N*DW/8-1:0] s_wstrb;
    logic [N-1:0]      s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [N-1:0]      s_rlast, s_rvalid, s_rready;
    logic [MIW-1:0]    m_awid, m_arid, m_bid, m_rid;
    logic [AW-1:0]     m_awaddr, m_araddr;
    logic [7:0]        m_awlen, m_arlen;
    logic [2:0]        m_awsize, m_arsize;
    logic [1:0]        m_awburst, m_arburst, m_bresp, m_rresp;
    logic              m_awvalid, m_awready, m_arvalid, m_arready;
    logic [DW-1:0]     m_wdata, m_rdata;
    logic [DW/8-1:0]   m_wstrb;
    logic              m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
    logic              m_rlast, m_rvalid, m_rready;

    logic [N3*IW-1:0]   t_awid, t_arid, t_bid, t_rid;
    logic [N3*AW-1:0]   t_awaddr, t_araddr;
    logic [N3*8-1:0]    t_awlen, t_arlen;
    logic [N3*3-1:0]    t_awsize, t_arsize;
    logic [N3*2-1:0]    t_awburst, t_arburst, t_bresp, t_rresp;
    logic [N3-1:0]      t_awvalid, t_awready, t_arvalid, t_arready;
    logic [N3*DW-1:0]   t_wdata, t_rdata;
    logic [N3*DW/8-1:0] t_wstrb;
    logic [N3-1:0]      t_wlast, t_wvalid, t_wready, t_bvalid, t_bready;
    logic [N3-1:0]      t_rlast, t_rvalid, t_rready;
    logic [MIW3-1:0]    tm_awid, tm_arid, tm_bid, tm_rid;
    logic [AW-1:0]      tm_awaddr, tm_araddr;
    logic [7:0]         tm_awlen, tm_arlen;
    logic [2:0]         tm_awsize, tm_arsize;
    logic [1:0]         tm_awburst, tm_arburst;
    logic               tm_awvalid, tm_arvalid;
    logic [DW-1:0]      tm_wdata;
    logic [DW/8-1:0]    tm_wstrb;
    logic               tm_wlast, tm_wvalid, tm_bready, tm_rready;

    logic [MIW+AW-1:0] addr_q [$];
    logic [DW:0]       data_q [$];

    axi4_master_arbiter #(
        .C_MASTERS(N), .C_THREAD_ID_WIDTH(IW), .C_ADDR_WIDTH(AW),
        .C_DATA_WIDTH(DW), .C_MAX_OUTSTANDING_W(4)
    ) dut (
        .MCLK(MCLK), .nRST(nRST),
        .S_AWID(s_awid), .S_AWADDR(s_awaddr), .S_AWLEN(s_awlen), .S_AWSIZE(s_awsize),
        .S_AWBURST(s_awburst), .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
        .S_WDATA(s_wdata), .S_WSTRB(s_wstrb), .S_WLAST(s_wlast), .S_WVALID(s_wvalid),
        .S_WREADY(s_wready),
        .S_BID(s_bid), .S_BRESP(s_bresp), .S_BVALID(s_bvalid), .S_BREADY(s_bready),
        .S_ARID(s_arid), .S_ARADDR(s_araddr), .S_ARLEN(s_arlen), .S_ARSIZE(s_arsize),
        .S_ARBURST(s_arburst), .S_ARVALID(s_arvalid), .S_ARREADY(s_arready),
        .S_RID(s_rid), .S_RDATA(s_rdata), .S_RRESP(s_rresp), .S_RLAST(s_rlast),
        .S_RVALID(s_rvalid), .S_RREADY(s_rready),
        .M_AWID(m_awid), .M_AWADDR(m_awaddr), .M_AWLEN(m_awlen), .M_AWSIZE(m_awsize),
        .M_AWBURST(m_awburst), .M_AWVALID(m_awvalid), .M_AWREADY(m_awready),
        .M_WDATA(m_wdata), .M_WSTRB(m_wstrb), .M_WLAST(m_wlast), .M_WVALID(m_wvalid),
        .M_WREADY(m_wready),
        .M_BID(m_bid), .M_BRESP(m_bresp), .M_BVALID(m_bvalid), .M_BREADY(m_bready),
        .M_ARID(m_arid), .M_ARADDR(m_araddr), .M_ARLEN(m_arlen), .M_ARSIZE(m_arsize),
        .M_ARBURST(m_arburst), .M_ARVALID(m_arvalid), .M_ARREADY(m_arready),
        .M_RID(m_rid), .M_RDATA(m_rdata), .M_RRESP(m_rresp), .M_RLAST(m_rlast),
        .M_RVALID(m_rvalid), .M_RREADY(m_rready)
    );

    axi4_master_arbiter #(
        .C_MASTERS(N3), .C_THREAD_ID_WIDTH(IW), .C_ADDR_WIDTH(AW),
        .C_DATA_WIDTH(DW), .C_MAX_OUTSTANDING_W(4)
    ) dut3 (
        .MCLK(MCLK), .nRST(nRST),
        .S_AWID(t_awid), .S_AWADDR(t_awaddr), .S_AWLEN(t_awlen), .S_AWSIZE(t_awsize),
        .S_AWBURST(t_awburst), .S_AWVALID(t_awvalid), .S_AWREADY(t_awready),
        .S_WDATA(t_wdata), .S_WSTRB(t_wstrb), .S_WLAST(t_wlast), .S_WVALID(t_wvalid),
        .S_WREADY(t_wready),
        .S_BID(t_bid), .S_BRESP(t_bresp), .S_BVALID(t_bvalid), .S_BREADY(t_bready),
        .S_ARID(t_arid), .S_ARADDR(t_araddr), .S_ARLEN(t_arlen), .S_ARSIZE(t_arsize),
        .S_ARBURST(t_arburst), .S_ARVALID(t_arvalid), .S_ARREADY(t_arready),
        .S_RID(t_rid), .S_RDATA(t_rdata), .S_RRESP(t_rresp), .S_RLAST(t_rlast),
        .S_RVALID(t_rvalid), .S_RREADY(t_rready),
        .M_AWID(tm_awid), .M_AWADDR(tm_awaddr), .M_AWLEN(tm_awlen), .M_AWSIZE(tm_awsize),
        .M_AWBURST(tm_awburst), .M_AWVALID(tm_awvalid), .M_AWREADY(1'b1),
        .M_WDATA(tm_wdata), .M_WSTRB(tm_wstrb), .M_WLAST(tm_wlast), .M_WVALID(tm_wvalid),
        .M_WREADY(1'b1),
        .M_BID(tm_bid), .M_BRESP(2'b00), .M_BVALID(m_bvalid), .M_BREADY(tm_bready),
        .M_ARID(tm_arid), .M_ARADDR(tm_araddr), .M_ARLEN(tm_arlen), .M_ARSIZE(tm_arsize),
        .M_ARBURST(tm_arburst), .M_ARVALID(tm_arvalid), .M_ARREADY(1'b1),
        .M_RID(tm_rid), .M_RDATA(m_rdata), .M_RRESP(2'b00), .M_RLAST(1'b0),
        .M_RVALID(m_rvalid), .M_RREADY(tm_rready)
    );

    task automatic do_reset();
        @(posedge MCLK); #1;
        nRST = 1'b0;
        s_awvalid = '0; s_arvalid = '0; s_wvalid = '0; s_wlast = '0;
        m_bvalid = 1'b0; m_rvalid = 1'b0;
        @(posedge MCLK); #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        s_awvalid = '1; s_arvalid = '1; s_wvalid = '1; s_wlast = '1;
        for (int i = 0; i < 2; i++) begin
            @(posedge MCLK);
            @(negedge MCLK);
            total++;
            if ({m_awvalid, m_arvalid} !== 2'b00) begin
                bad++; $display("FAIL reset_mvalid: got %b want 00", {m_awvalid, m_arvalid});
            end
            total++;
            if ({s_awready, s_arready, s_wready} !== 6'b0) begin
                bad++; $display("FAIL reset_sready: got %b want 000000", {s_awready, s_arready, s_wready});
            end
        end
        @(posedge MCLK); #1;
        s_awvalid = '0; s_arvalid = '0; s_wvalid = '0; s_wlast = '0;
        nRST = 1'b1;
    endtask

    // Drive one address request per masked master; expected downstream
    // {prefixed ID, addr} are queued in grant order starting at 'first'.
    task automatic addr_round(input bit is_ar, input logic [N-1:0] mask, input int first);
        logic [N-1:0] pend, rdy;
        logic [MIW+AW-1:0] exp_v, got;
        logic [AW-1:0] a;
        int m;
        addr_seq++;
        for (int k = 0; k < N; k++) begin
            a = 32'h1000_0000 + 32'(addr_seq) * 32'h100 + 32'(k) * 32'h4;
            if (is_ar) s_araddr[k*AW +: AW] = a;
            else       s_awaddr[k*AW +: AW] = a;
        end
        for (int k = 0; k < N; k++) begin
            m = (first + k) % N;
            if (mask[m]) begin
                a = 32'h1000_0000 + 32'(addr_seq) * 32'h100 + 32'(m) * 32'h4;
                addr_q.push_back({1'(m), (is_ar ? s_arid[m*IW +: IW] : s_awid[m*IW +: IW]), a});
            end
        end
        pend = mask;
        if (is_ar) s_arvalid = pend; else s_awvalid = pend;
        for (int c = 0; c < 12 && (pend != 0 || addr_q.size() != 0); c++) begin
            @(negedge MCLK);
            rdy = is_ar ? s_arready : s_awready;
            if (is_ar ? m_arvalid : m_awvalid) begin
                got = is_ar ? {m_arid, m_araddr} : {m_awid, m_awaddr};
                total++;
                if (addr_q.size() == 0) begin
                    bad++; $display("FAIL addr_extra: got %h want none", got);
                end else begin
                    exp_v = addr_q.pop_front();
                    if (got !== exp_v) begin
                        bad++; $display("FAIL addr_order: got id/addr %h want %h", got, exp_v);
                    end
                end
            end
            @(posedge MCLK); #1;
            pend = pend & ~rdy;
            if (is_ar) s_arvalid = pend; else s_awvalid = pend;
        end
        total++;
        if (pend != 0 || addr_q.size() != 0) begin
            bad++; $display("FAIL addr_timeout: pending %b left %0d want 0", pend, addr_q.size());
            addr_q.delete();
        end
        if (is_ar) s_arvalid = '0; else s_awvalid = '0;
    endtask

    task automatic test_rr();
        do_reset();
        s_awid = 2'b11;
        addr_round(1'b0, 2'b11, 0);
        addr_round(1'b0, 2'b11, 0);
        do_reset();
        s_awid = 2'b01;
        addr_round(1'b0, 2'b01, 0);
        addr_round(1'b0, 2'b11, 1);
    endtask

    task automatic test_ar();
        do_reset();
        s_arid = 2'b10;
        addr_round(1'b1, 2'b11, 0);
        addr_round(1'b1, 2'b10, 1);
        addr_round(1'b1, 2'b11, 0);
    endtask

    task automatic test_order();
        logic [N-1:0] rdy;
        logic [DW:0] exp_v;
        int beat1;
        do_reset();
        s_awid = 2'b00;
        s_awlen = 16'h0300;
        s_wvalid = 2'b01; s_wlast = 2'b01;
        s_wdata[0 +: DW] = 32'hA0A0_0000;
        @(negedge MCLK);
        total++;
        if (s_wready !== 2'b00 || m_wvalid !== 1'b0) begin
            bad++; $display("FAIL w_empty: got wready %b wvalid %b want 00 0", s_wready, m_wvalid);
        end
        @(posedge MCLK); #1;
        addr_round(1'b0, 2'b10, 1);
        addr_round(1'b0, 2'b01, 0);
        for (int k = 0; k < 4; k++) data_q.push_back({(k == 3), 32'hB1B1_0000 + 32'(k)});
        data_q.push_back({1'b1, 32'hA0A0_0000});
        beat1 = 0;
        s_wvalid[1] = 1'b1; s_wdata[DW +: DW] = 32'hB1B1_0000; s_wlast[1] = 1'b0;
        for (int c = 0; c < 20 && data_q.size() != 0; c++) begin
            @(negedge MCLK);
            rdy = s_wready;
            if (beat1 < 4) begin
                total++;
                if (s_wready[0] !== 1'b0) begin
                    bad++; $display("FAIL w_order_block: got wready0 %b want 0 at beat %0d", s_wready[0], beat1);
                end
            end
            if (m_wvalid && m_wready) begin
                total++;
                exp_v = data_q.pop_front();
                if ({m_wlast, m_wdata} !== exp_v) begin
                    bad++; $display("FAIL w_data: got %h want %h", {m_wlast, m_wdata}, exp_v);
                end
            end
            @(posedge MCLK); #1;
            if (rdy[1]) begin
                beat1++;
                s_wvalid[1] = (beat1 < 4);
                s_wdata[DW +: DW] = 32'hB1B1_0000 + 32'(beat1);
                s_wlast[1] = (beat1 == 3);
            end
            if (rdy[0]) s_wvalid[0] = 1'b0;
        end
        total++;
        if (data_q.size() != 0) begin
            bad++; $display("FAIL w_timeout: got %0d left want 0", data_q.size());
            data_q.delete();
        end
        s_wvalid = '0; s_wlast = '0;
        @(negedge MCLK);
        total++;
        if (s_wready !== 2'b00) begin
            bad++; $display("FAIL w_drained: got %b want 00", s_wready);
        end
        s_awlen = '0;
    endtask

    task automatic test_fifo_full();
        logic [MIW+AW-1:0] exp_v;
        do_reset();
        s_awid = 2'b00;
        for (int i = 0; i < 4; i++) addr_round(1'b0, 2'b01, 0);
        addr_seq++;
        s_awaddr[0 +: AW] = 32'h5555_0000;
        addr_q.push_back({1'b0, 1'b0, 32'h5555_0000});
        s_awvalid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge MCLK);
            total++;
            if (s_awready !== 2'b00) begin
                bad++; $display("FAIL fifo_full_block: got %b want 00", s_awready);
            end
            @(posedge MCLK); #1;
        end
        s_wvalid = 2'b01; s_wlast = 2'b01;
        @(negedge MCLK);
        total++;
        if (s_awready !== 2'b00 || s_wready !== 2'b01) begin
            bad++; $display("FAIL fifo_pop_cycle: got awready %b wready %b want 00 01", s_awready, s_wready);
        end
        @(posedge MCLK); #1;
        s_wvalid = '0; s_wlast = '0;
        @(negedge MCLK);
        total++;
        if (s_awready !== 2'b01) begin
            bad++; $display("FAIL fifo_after_pop: got %b want 01", s_awready);
        end
        @(posedge MCLK); #1;
        s_awvalid = '0;
        @(negedge MCLK);
        total++;
        exp_v = addr_q.pop_front();
        if (m_awvalid !== 1'b1 || {m_awid, m_awaddr} !== exp_v) begin
            bad++; $display("FAIL fifo_fifth_aw: got valid %b %h want 1 %h", m_awvalid, {m_awid, m_awaddr}, exp_v);
        end
    endtask

    task automatic test_routing();
        logic [DW:0] exp_v;
        logic rdy;
        int beat;
        do_reset();
        s_rready = 2'b01;
        m_rid = 2'b10; m_rresp = 2'b00;
        beat = 0;
        m_rdata = 32'hC0DE_0000; m_rlast = 1'b0; m_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) data_q.push_back({(k == 3), 32'hC0DE_0000 + 32'(k)});
        for (int c = 0; c < 12 && data_q.size() != 0; c++) begin
            @(negedge MCLK);
            rdy = m_rready;
            total++;
            if (s_rvalid !== 2'b10 || s_rid[IW +: IW] !== 1'b0) begin
                bad++; $display("FAIL r_route: got rvalid %b rid %b want 10 0", s_rvalid, s_rid[IW +: IW]);
            end
            if (c < 2) begin
                total++;
                if (m_rready !== 1'b0) begin
                    bad++; $display("FAIL r_stall: got m_rready %b want 0", m_rready);
                end
            end
            if (s_rvalid[1] && s_rready[1]) begin
                total++;
                exp_v = data_q.pop_front();
                if ({s_rlast[1], s_rdata[DW +: DW]} !== exp_v) begin
                    bad++; $display("FAIL r_data: got %h want %h", {s_rlast[1], s_rdata[DW +: DW]}, exp_v);
                end
            end
            @(posedge MCLK); #1;
            if (c == 1) s_rready = 2'b11;
            if (rdy) begin
                beat++;
                m_rvalid = (beat < 4);
                m_rdata = 32'hC0DE_0000 + 32'(beat);
                m_rlast = (beat == 3);
            end
        end
        total++;
        if (data_q.size() != 0) begin
            bad++; $display("FAIL r_timeout: got %0d left want 0", data_q.size());
            data_q.delete();
        end
        m_rvalid = 1'b0;
        m_bid = 2'b01; m_bresp = 2'b10; m_bvalid = 1'b1; s_bready = 2'b10;
        @(negedge MCLK);
        total++;
        if (s_bvalid !== 2'b01 || m_bready !== 1'b0 || s_bid[0] !== 1'b1 || s_bresp[1:0] !== 2'b10) begin
            bad++; $display("FAIL b_route: got bvalid %b bready %b bid %b want 01 0 1", s_bvalid, m_bready, s_bid[0]);
        end
        s_bready = 2'b01;
        @(negedge MCLK);
        total++;
        if (m_bready !== 1'b1) begin
            bad++; $display("FAIL b_ready: got %b want 1", m_bready);
        end
        m_bvalid = 1'b0;
    endtask

    task automatic test_out_of_range();
        tm_bid = 3'b110; tm_rid = 3'b110;
        t_bready = 3'b000; t_rready = 3'b000;
        m_bvalid = 1'b1; m_rvalid = 1'b1;
        @(negedge MCLK);
        total++;
        if (tm_bready !== 1'b1 || t_bvalid !== 3'b000) begin
            bad++; $display("FAIL oor_b: got bready %b bvalid %b want 1 000", tm_bready, t_bvalid);
        end
        total++;
        if (tm_rready !== 1'b1 || t_rvalid !== 3'b000) begin
            bad++; $display("FAIL oor_r: got rready %b rvalid %b want 1 000", tm_rready, t_rvalid);
        end
        tm_bid = 3'b100; t_bready = 3'b011;
        @(negedge MCLK);
        total++;
        if (tm_bready !== 1'b0 || t_bvalid !== 3'b100) begin
            bad++; $display("FAIL n3_b_route: got bready %b bvalid %b want 0 100", tm_bready, t_bvalid);
        end
        m_bvalid = 1'b0; m_rvalid = 1'b0;
    endtask

    initial begin
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        s_awvalid = '0; s_arvalid = '0;
        s_wdata = '0; s_wstrb = '1; s_wlast = '0; s_wvalid = '0;
        s_bready = '0; s_rready = '0;
        m_awready = 1'b1; m_arready = 1'b1; m_wready = 1'b1;
        m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
        m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        t_awid = '0; t_awaddr = '0; t_awlen = '0; t_awsize = '0; t_awburst = '0; t_awvalid = '0;
        t_arid = '0; t_araddr = '0; t_arlen = '0; t_arsize = '0; t_arburst = '0; t_arvalid = '0;
        t_wdata = '0; t_wstrb = '0; t_wlast = '0; t_wvalid = '0;
        t_bready = '0; t_rready = '0; tm_bid = '0; tm_rid = '0;
        nRST = 1'b0;
        test_reset();
        test_rr();
        test_ar();
        test_order();
        test_fifo_full();
        test_routing();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
